// File: rtl/alu_exec_if.sv
// ============================================================================
// Module   : alu_exec_if
// Summary  : Issue/result handshake bundle between ID/EX, the EX unit and EX/MEM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_exec_if #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3,
  parameter int SHAMT_W = 5
) ();
  logic               in_valid;
  logic               in_ready;
  logic [ALUOP_W-1:0] alu_op;
  logic [5:0]         funct;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  src_a;
  logic [DATA_W-1:0]  src_b;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  result;
  logic               zero;
  logic               overflow;
  logic               illegal;
  logic [DATA_W-1:0]  hi;
  logic [DATA_W-1:0]  lo;
  logic               busy;

  modport master (
    output in_valid, alu_op, funct, shamt, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal, hi, lo, busy
  );

  modport slave (
    input  in_valid, alu_op, funct, shamt, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal, hi, lo, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module   : alu_exec_unit
// Summary  : EX-stage ALU with registered valid/ready result stage and an
//            optional iterative mult/div engine (macro ALU_MULDIV_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3,
  parameter int SHAMT_W = 5
) (
  input wire logic  clk,
  input wire logic  rst_n,
  alu_exec_if.slave bus
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] w_res;
  logic              w_ovf;
  logic              w_ill;
  logic              w_md_start;
  logic              w_idle;
  logic              w_md_done;
  logic              w_fire;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_dif;
  logic [DATA_W-1:0] w_hi_q;
  logic [DATA_W-1:0] w_lo_q;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_ovf;
  logic              r_ill;

  assign w_sum    = bus.src_a + bus.src_b;
  assign w_dif    = bus.src_a - bus.src_b;
  assign w_fire   = bus.in_valid && bus.in_ready;
  assign bus.in_ready = w_idle && (!r_out_valid || bus.out_ready);

`ifdef ALU_MULDIV_EN
  logic w_md_mul;
  logic w_md_sgn;
`endif

  always_comb begin
    w_res      = '0;
    w_ovf      = 1'b0;
    w_ill      = 1'b0;
    w_md_start = 1'b0;
`ifdef ALU_MULDIV_EN
    w_md_mul   = 1'b0;
    w_md_sgn   = 1'b0;
`endif
    case (bus.alu_op)
      ALUOP_W'(0): begin
        w_res = w_sum;
        w_ovf = (bus.src_a[MSB] == bus.src_b[MSB]) && (w_sum[MSB] != bus.src_a[MSB]);
      end
      ALUOP_W'(1): begin
        w_res = w_dif;
        w_ovf = (bus.src_a[MSB] != bus.src_b[MSB]) && (w_dif[MSB] != bus.src_a[MSB]);
      end
      ALUOP_W'(2): begin
        case (bus.funct)
          6'h20: begin
            w_res = w_sum;
            w_ovf = (bus.src_a[MSB] == bus.src_b[MSB]) && (w_sum[MSB] != bus.src_a[MSB]);
          end
          6'h21: w_res = w_sum;
          6'h22: begin
            w_res = w_dif;
            w_ovf = (bus.src_a[MSB] != bus.src_b[MSB]) && (w_dif[MSB] != bus.src_a[MSB]);
          end
          6'h23: w_res = w_dif;
          6'h24: w_res = bus.src_a & bus.src_b;
          6'h25: w_res = bus.src_a | bus.src_b;
          6'h26: w_res = bus.src_a ^ bus.src_b;
          6'h27: w_res = ~(bus.src_a | bus.src_b);
          6'h2A: w_res = {{(DATA_W-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
          6'h2B: w_res = {{(DATA_W-1){1'b0}}, (bus.src_a < bus.src_b)};
          6'h00: w_res = bus.src_b << bus.shamt;
          6'h02: w_res = bus.src_b >> bus.shamt;
          6'h03: w_res = $unsigned($signed(bus.src_b) >>> bus.shamt);
`ifdef ALU_MULDIV_EN
          6'h10: w_res = w_hi_q;
          6'h12: w_res = w_lo_q;
          6'h18: begin w_md_start = 1'b1; w_md_mul = 1'b1; w_md_sgn = 1'b1; end
          6'h19: begin w_md_start = 1'b1; w_md_mul = 1'b1; end
          6'h1A: begin w_md_start = 1'b1; w_md_sgn = 1'b1; end
          6'h1B: w_md_start = 1'b1;
`endif
          default: w_ill = 1'b1;
        endcase
      end
      ALUOP_W'(3): w_res = bus.src_a & bus.src_b;
      ALUOP_W'(4): w_res = bus.src_a | bus.src_b;
      ALUOP_W'(5): w_res = {{(DATA_W-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      ALUOP_W'(6): w_res = bus.src_b << 16;
      ALUOP_W'(7): w_res = bus.src_a ^ bus.src_b;
      default:     w_ill = 1'b1;
    endcase
  end

  // Result register only moves on a new transfer or an engine completion,
  // so a stalled result stays stable until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
    end else if (w_fire && !w_md_start) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_zero      <= (w_res == '0);
      r_ovf       <= w_ovf;
      r_ill       <= w_ill;
    end else if (w_fire) begin
      r_out_valid <= 1'b0;
    end else if (w_md_done) begin
      r_out_valid <= 1'b1;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_ovf;
  assign bus.illegal   = r_ill;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MD_RUN = 2'd1,
    S_MD_FIX = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SHAMT_W-1:0]  r_cnt;
  logic [DATA_W:0]     r_acc;
  logic [DATA_W-1:0]   r_q;
  logic [DATA_W-1:0]   r_mb;
  logic [DATA_W-1:0]   r_a;
  logic                r_mul;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_bzero;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_busy;

  logic                w_a_neg;
  logic                w_b_neg;
  logic [DATA_W:0]     w_madd;
  logic [DATA_W:0]     w_trial;
  logic [DATA_W+1:0]   w_diff;
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_prod_s;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;

  assign w_idle    = (r_state == S_IDLE);
  assign w_md_done = (r_state == S_MD_FIX);
  assign w_hi_q    = r_hi;
  assign w_lo_q    = r_lo;

  assign w_a_neg  = w_md_sgn && bus.src_a[MSB];
  assign w_b_neg  = w_md_sgn && bus.src_b[MSB];
  assign w_madd   = r_acc + (r_q[0] ? {1'b0, r_mb} : '0);
  assign w_trial  = {r_acc[DATA_W-1:0], r_q[MSB]};
  assign w_diff   = {1'b0, w_trial} - {2'b00, r_mb};
  assign w_prod   = {r_acc[DATA_W-1:0], r_q};
  assign w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo    = r_neg_q ? (~r_q + 1'b1) : r_q;
  assign w_rem    = r_neg_r ? (~r_acc[DATA_W-1:0] + 1'b1) : r_acc[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_fire && w_md_start) w_state_nxt = S_MD_RUN;
      S_MD_RUN: if (r_cnt == '0) w_state_nxt = S_MD_FIX;
      S_MD_FIX: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Both engines work on magnitudes; signs are reapplied in MD_FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_mb    <= '0;
      r_a     <= '0;
      r_mul   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bzero <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_fire && w_md_start) begin
          r_cnt   <= SHAMT_W'(DATA_W - 1);
          r_acc   <= '0;
          r_q     <= w_a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
          r_mb    <= w_b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
          r_a     <= bus.src_a;
          r_mul   <= w_md_mul;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_bzero <= (bus.src_b == '0);
          r_busy  <= 1'b1;
        end
        S_MD_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_mul) begin
            {r_acc, r_q} <= {w_madd, r_q} >> 1;
          end else if (!w_diff[DATA_W+1]) begin
            r_acc <= w_diff[DATA_W:0];
            r_q   <= {r_q[DATA_W-2:0], 1'b1};
          end else begin
            r_acc <= w_trial;
            r_q   <= {r_q[DATA_W-2:0], 1'b0};
          end
        end
        S_MD_FIX: begin
          r_busy <= 1'b0;
          if (r_mul) begin
            {r_hi, r_lo} <= w_prod_s;
          end else if (r_bzero) begin
            r_lo <= '1;
            r_hi <= r_a;
          end else begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = r_busy;
`else
  assign w_idle    = 1'b1;
  assign w_md_done = 1'b0;
  assign w_hi_q    = '0;
  assign w_lo_q    = '0;
  assign bus.hi    = '0;
  assign bus.lo    = '0;
  assign bus.busy  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module   : tb_alu_exec_unit
// Summary  : Directed-vector bench for alu_exec_unit (both ALU_MULDIV_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 3;
  localparam int SHAMT_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  alu_exec_if #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .SHAMT_W(SHAMT_W)) bus ();

  alu_exec_unit #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offer one operation at the falling edge; returns #1 after the transfer edge.
  task automatic issue(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.shamt    = sh;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.in_valid = 1'b1;
    check("in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

`ifdef ALU_MULDIV_EN
  task automatic md_wait(output int cyc, output int bcnt, output bit rdy);
    cyc  = 0;
    bcnt = 0;
    rdy  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        cyc = k;
        break;
      end
      if (bus.busy) bcnt++;
      if (bus.in_ready) rdy = 1'b1;
    end
  endtask
`endif

  initial begin
    int          cyc;
    int          bcnt;
    bit          rdy;
    bit          stable;
    logic [31:0] held;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_op    = '0;
    bus.funct     = '0;
    bus.shamt     = '0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result",    64'(bus.result),    64'd0);
    check("rst_zero",      64'(bus.zero),      64'd0);
    check("rst_hi_lo",     {bus.hi, bus.lo},   64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);

    issue(3'd2, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'd1);
    check("add_valid",  64'(bus.out_valid), 64'd1);
    check("add_result", 64'(bus.result),    64'h8000_0000);
    check("add_ovf",    64'(bus.overflow),  64'd1);
    check("add_zero",   64'(bus.zero),      64'd0);
    issue(3'd2, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'd1);
    check("addu_result", 64'(bus.result),   64'h8000_0000);
    check("addu_ovf",    64'(bus.overflow), 64'd0);

    issue(3'd1, 6'h00, 5'd0, 32'h1234, 32'h1234);
    check("sub_result", 64'(bus.result), 64'd0);
    check("sub_zero",   64'(bus.zero),   64'd1);
    issue(3'd2, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1);
    check("slt",  64'(bus.result), 64'd1);
    issue(3'd2, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'd1);
    check("sltu", 64'(bus.result), 64'd0);

    issue(3'd2, 6'h03, 5'd4, 32'h0, 32'h8000_0000);
    check("sra", 64'(bus.result), 64'hF800_0000);
    issue(3'd2, 6'h02, 5'd4, 32'h0, 32'h8000_0000);
    check("srl", 64'(bus.result), 64'h0800_0000);
    issue(3'd2, 6'h00, 5'd4, 32'h0, 32'h0000_0003);
    check("sll", 64'(bus.result), 64'h30);

    issue(3'd6, 6'h00, 5'd0, 32'h0, 32'h0000_1234);
    check("lui", 64'(bus.result), 64'h1234_0000);
    issue(3'd7, 6'h00, 5'd0, 32'hFF00_FF00, 32'h0F0F_0F0F);
    check("xor", 64'(bus.result), 64'hF00F_F00F);
    issue(3'd2, 6'h27, 5'd0, 32'h0, 32'hF);
    check("nor", 64'(bus.result), 64'hFFFF_FFF0);
    issue(3'd1, 6'h00, 5'd0, 32'h8000_0000, 32'd1);
    check("sub_ovf", 64'(bus.overflow), 64'd1);

    issue(3'd2, 6'h3F, 5'd0, 32'h5, 32'h6);
    check("bad_funct_valid",   64'(bus.out_valid), 64'd1);
    check("bad_funct_illegal", 64'(bus.illegal),   64'd1);
    check("bad_funct_result",  64'(bus.result),    64'd0);

    // Single-cycle stall: held outputs and no acceptance while out_ready is low.
    issue(3'd4, 6'h00, 5'd0, 32'hA0, 32'h05);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_op    = 3'd0;
    stable        = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.result !== 32'hA5 || !bus.out_valid || bus.in_ready) stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("alu_stall_hold", 64'(stable), 64'd1);
    bus.out_ready = 1'b1;

`ifdef ALU_MULDIV_EN
    issue(3'd2, 6'h18, 5'd0, 32'hFFFF_FFFD, 32'd7);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_op    = 3'd0;
    bus.src_a     = 32'd1;
    bus.src_b     = 32'd1;
    md_wait(cyc, bcnt, rdy);
    check("mult_latency",  64'(cyc),  64'd33);
    check("mult_busy_cyc", 64'(bcnt), 64'd32);
    check("mult_no_ready", 64'(rdy),  64'd0);
    check("mult_result",   64'(bus.result),  64'd0);
    check("mult_zero",     64'(bus.zero),    64'd1);
    check("mult_busy_end", 64'(bus.busy),    64'd0);
    check("mult_hilo",     {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    held   = bus.result;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.result !== held || !bus.zero || !bus.out_valid || bus.in_ready) stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("mult_stall_hold", 64'(stable), 64'd1);
    bus.out_ready = 1'b1;
    issue(3'd2, 6'h12, 5'd0, 32'h0, 32'h0);
    check("mflo", 64'(bus.result), 64'hFFFF_FFEB);
    issue(3'd2, 6'h10, 5'd0, 32'h0, 32'h0);
    check("mfhi", 64'(bus.result), 64'hFFFF_FFFF);

    issue(3'd2, 6'h19, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_wait(cyc, bcnt, rdy);
    check("multu_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    issue(3'd2, 6'h1B, 5'd0, 32'd100, 32'd0);
    md_wait(cyc, bcnt, rdy);
    check("divz_latency", 64'(cyc), 64'd33);
    check("divz_hilo", {bus.hi, bus.lo}, {32'd100, 32'hFFFF_FFFF});
    issue(3'd2, 6'h1A, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    md_wait(cyc, bcnt, rdy);
    check("div_minneg_hilo", {bus.hi, bus.lo}, {32'h0, 32'h8000_0000});
    issue(3'd2, 6'h1A, 5'd0, 32'hFFFF_FFF9, 32'd2);
    md_wait(cyc, bcnt, rdy);
    check("div_signed_hilo", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    issue(3'd2, 6'h1B, 5'd0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    check("div_running_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",      64'(bus.busy),      64'd0);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_hilo",      {bus.hi, bus.lo},   64'd0);
`else
    issue(3'd2, 6'h18, 5'd0, 32'hFFFF_FFFD, 32'd7);
    check("nomd_mult_valid",   64'(bus.out_valid), 64'd1);
    check("nomd_mult_illegal", 64'(bus.illegal),   64'd1);
    check("nomd_busy",         64'(bus.busy),      64'd0);
    issue(3'd2, 6'h10, 5'd0, 32'h0, 32'h0);
    check("nomd_mfhi_illegal", 64'(bus.illegal),   64'd1);
    check("nomd_hilo",         {bus.hi, bus.lo},   64'd0);

    issue(3'd0, 6'h00, 5'd0, 32'd9, 32'd9);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_result",    64'(bus.result),    64'd0);
    bus.out_ready = 1'b1;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 6'h00, 5'd0, 32'd2, 32'd3);
    check("post_rst_valid", 64'(bus.out_valid), 64'd1);
    check("post_rst_add",   64'(bus.result),    64'd5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised successor of the combinational ALU-control decoder. It merges the aluOp/funct decode with the ALU datapath behind a registered valid/ready output stage, and adds an iterative multiply/divide engine with HI/LO registers. It sits in the EX stage of the multi-cycle pipeline, between ID/EX and EX/MEM.

Parameters:
DATA_W, 32, operand/result width; must be a power of two, at least 8
ALUOP_W, 3, width of the main-control ALU opcode
SHAMT_W, 5, shift-amount width; must equal log2(DATA_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  unit can accept an operation this cycle
alu_op  in  ALUOP_W  main-control opcode
funct  in  6  R-type funct field
shamt  in  SHAMT_W  shift amount
src_a  in  DATA_W  operand A (rs)
src_b  in  DATA_W  operand B (rt or immediate)
out_valid  out  1  result register valid
out_ready  in  1  downstream accepts result
result  out  DATA_W  registered result
zero  out  1  registered (result == 0)
overflow  out  1  signed overflow of add/sub (trapping forms only)
illegal  out  1  undecodable alu_op/funct
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register
busy  out  1  mult/div engine running

Behaviour:
- Reset (async, rst_n low): out_valid, result, zero, overflow, illegal, hi, lo, busy all 0; FSM to IDLE. Applies mid-operation; the partial mult/div is discarded and HI/LO are cleared.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A transfer occurs on in_valid && in_ready at a clk edge.
- alu_op decode: 0 add; 1 sub; 2 R-type per funct; 3 and; 4 or; 5 slt; 6 lui (src_b << 16); 7 xor. Values above 7 set illegal, if ALUOP_W allows them.
- funct decode (alu_op=2): 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x2B sltu, 0x00 sll, 0x02 srl, 0x03 sra (shift src_b by shamt), 0x10 mfhi, 0x12 mflo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
- Any other funct: result 0, illegal=1, still completes with 1-cycle latency.
- Single-cycle ops: result, zero, overflow and illegal are registered and out_valid rises on the edge after the transfer (latency 1).
- overflow: only for add/sub (alu_op 0/1, funct 0x20/0x22). Result is written regardless. slt/sltu yield 0 or 1, zero-extended.
- Output hold: while out_valid && !out_ready, all outputs are held stable. The result register is updated only on a new transfer.
- mfhi/mflo return HI/LO as they stand after any completed mult/div.
- FSM states:
  - IDLE: accepting a mult/div transfer moves to MD_RUN; counter=DATA_W-1; busy=1.
  - MD_RUN: one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes). Moves to MD_FIX when the counter reaches 0.
  - MD_FIX: sign correction; writes HI/LO; out_valid=1 with result=0, zero=1, illegal=0. Then IDLE, busy=0.
- mult/div total latency = DATA_W+1 cycles from transfer to out_valid.
- mult/multu: {HI,LO} = full 2*DATA_W product.
- div/divu: LO = quotient, HI = remainder. The remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = dividend; latency unchanged.
- Signed most-negative / -1: LO = most-negative, HI = 0.
- in_valid while busy is ignored: in_ready=0, and the offered operation stays with the upstream stage.

Optional Feature:
ALU_MULDIV_EN:
- Defined: mult/div engine, HI/LO registers and mfhi/mflo are present as described above.
- Undefined: funct 0x10/0x12/0x18-0x1B decode as illegal with 1-cycle latency; hi, lo and busy are tied 0; no FSM is synthesised.

Test Plan:
1. alu_op=2, funct=0x20, A=0x7FFFFFFF, B=1 -> next cycle: result=0x80000000, overflow=1, zero=0. Same operands with funct=0x21 -> overflow=0.
2. alu_op=1, A=B=0x1234 -> result=0, zero=1. alu_op=2, funct=0x2A, A=0xFFFFFFFF, B=1 -> result=1. funct=0x2B with the same operands -> result=0.
3. funct=0x03, B=0x80000000, shamt=4 -> result=0xF8000000. funct=0x02 with the same operands -> 0x08000000.
4. funct=0x18, A=-3, B=7, out_ready held low 5 cycles after out_valid:
   - busy for 32 cycles; out_valid at cycle 33.
   - outputs stable during the stall; in_ready=0 throughout.
   - mflo then returns 0xFFFFFFEB and mfhi returns 0xFFFFFFFF.
5. funct=0x1B, A=100, B=0 -> LO=0xFFFFFFFF, HI=100. funct=0x1A, A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
6. Start div, pull rst_n low at cycle 10 -> busy, out_valid, hi and lo are 0 immediately. After release, add 2+3 returns 5 with latency 1.
